// File: rtl/cp0_timer_irq.sv
// cp0_timer_irq: CP0-style interrupt controller with NUM_TIMERS count/compare
// channels, HWI_WIDTH level interrupt lines and a memory-mapped register file.
// Optional tick prescaler is built when CP0_TIMER_PRESCALE_EN is defined;
// otherwise every cycle is a tick and PRESCALE reads as zero.

module cp0_timer_chan #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   count_we,
    input  logic                   compare_we,
    input  logic                   ctrl_we,
    input  logic [COUNT_WIDTH-1:0] wdata,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] compare,
    output logic [1:0]             ctrl,
    output logic                   match
);
    // ctrl[0] = EN, ctrl[1] = AUTO_RELOAD; a zero compare value is "off"
    assign match = tick && ctrl[0] && (compare != '0) && (count == compare);

    // Counter: a software write wins over the tick; auto-reload wraps to 0 on match
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (count_we)
            count <= wdata;
        else if (tick && ctrl[0])
            count <= (match && ctrl[1]) ? '0 : count + 1'b1;
    end

    // Compare and control registers, written by software only
    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= '0;
            ctrl    <= '0;
        end else begin
            if (compare_we) compare <= wdata;
            if (ctrl_we)    ctrl    <= wdata[1:0];
        end
    end
endmodule

module cp0_timer_irq #(
    parameter int NUM_TIMERS     = 4,
    parameter int COUNT_WIDTH    = 32,
    parameter int HWI_WIDTH      = 5,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            write_en,
    input  logic [4:0]                      write_addr,
    input  logic [31:0]                     write_data,
    input  logic [4:0]                      read_addr,
    output logic [31:0]                     data_out,
    input  logic [HWI_WIDTH-1:0]            interrupt,
    output logic                            int_pending,
    output logic [HWI_WIDTH+NUM_TIMERS-1:0] ip_status
);
    localparam int NSRC = HWI_WIDTH + NUM_TIMERS;

    logic [NSRC-1:0]                         mask_src;
    logic                                    mask_ie;
    logic [HWI_WIDTH-1:0]                    hwi_pend;
    logic [NUM_TIMERS-1:0]                   tmr_pend;
    logic [NSRC-1:0]                         pending;
    logic                                    tick;
    logic [31:0]                             presc_rd;
    logic [31:0]                             rd_data;
    logic [NUM_TIMERS-1:0][COUNT_WIDTH-1:0]  cnt_q;
    logic [NUM_TIMERS-1:0][COUNT_WIDTH-1:0]  cmp_q;
    logic [NUM_TIMERS-1:0][1:0]              ctrl_q;
    logic [NUM_TIMERS-1:0]                   match, cnt_we, cmp_we, ctrl_we;
    logic                                    mask_we, pend_we, presc_we;
    logic                                    unused_wdata;

    assign mask_we  = write_en && (write_addr == 5'd0);
    assign pend_we  = write_en && (write_addr == 5'd1);
    assign presc_we = write_en && (write_addr == 5'd2);
    // Upper write_data bits are meaningless for narrow configurations
    assign unused_wdata = ^write_data;

`ifdef CP0_TIMER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_cnt;

    assign tick     = (presc_cnt == presc_q);
    assign presc_rd = 32'(presc_q);

    // Prescaler counts 0..PRESCALE; a PRESCALE write restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            presc_cnt <= '0;
        end else if (presc_we) begin
            presc_q   <= write_data[PRESCALE_WIDTH-1:0];
            presc_cnt <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
        end
    end
`else
    logic [PRESCALE_WIDTH:0] unused_presc;

    assign tick         = 1'b1;
    assign presc_rd     = '0;
    assign unused_presc = {PRESCALE_WIDTH'(0), presc_we};
`endif

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
        assign cnt_we[gi]  = write_en && (write_addr == 5'(8 + gi));
        assign cmp_we[gi]  = write_en && (write_addr == 5'(16 + gi));
        assign ctrl_we[gi] = write_en && (write_addr == 5'(24 + gi));

        cp0_timer_chan #(.COUNT_WIDTH(COUNT_WIDTH)) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (tick),
            .count_we   (cnt_we[gi]),
            .compare_we (cmp_we[gi]),
            .ctrl_we    (ctrl_we[gi]),
            .wdata      (write_data[COUNT_WIDTH-1:0]),
            .count      (cnt_q[gi]),
            .compare    (cmp_q[gi]),
            .ctrl       (ctrl_q[gi]),
            .match      (match[gi])
        );
    end

    // Mask register: per-source enables plus global IE in bit 31
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_src <= '0;
            mask_ie  <= 1'b0;
        end else if (mask_we) begin
            mask_src <= write_data[NSRC-1:0];
            mask_ie  <= write_data[31];
        end
    end

    // HWI lines re-sampled every cycle; timer bits sticky, a match beats any clear
    always_ff @(posedge clk) begin
        if (rst) begin
            hwi_pend <= '0;
            tmr_pend <= '0;
        end else begin
            hwi_pend <= interrupt;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (match[i])
                    tmr_pend[i] <= 1'b1;
                else if ((pend_we && write_data[HWI_WIDTH+i]) || cmp_we[i])
                    tmr_pend[i] <= 1'b0;
            end
        end
    end

    assign pending = {tmr_pend, hwi_pend};

    // Read mux; unmapped and out-of-range channel addresses fall through to 0
    always_comb begin
        rd_data = '0;
        if (read_addr == 5'd0) rd_data = {mask_ie, 31'(mask_src)};
        if (read_addr == 5'd1) rd_data = 32'(pending);
        if (read_addr == 5'd2) rd_data = presc_rd;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (read_addr == 5'(8 + i))  rd_data = 32'(cnt_q[i]);
            if (read_addr == 5'(16 + i)) rd_data = 32'(cmp_q[i]);
            if (read_addr == 5'(24 + i)) rd_data = {30'd0, ctrl_q[i]};
        end
    end

    // Outputs are forced quiet while reset is held, before state has cleared
    assign data_out    = rst ? '0 : rd_data;
    assign ip_status   = rst ? '0 : pending;
    assign int_pending = !rst && mask_ie && |(pending & mask_src);
endmodule

// File: tb/tb_cp0_timer_irq.sv
// Scoreboard bench for cp0_timer_irq: the stimulus process queues expected
// values, a negedge monitor pops and compares. A second 16-bit, 2-channel
// instance shares the inputs for width and address-range cases.

module tb_cp0_timer_irq;
`ifdef CP0_TIMER_PRESCALE_EN
    localparam bit PS = 1'b1;
`else
    localparam bit PS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        write_en;
    logic [4:0]  write_addr, read_addr;
    logic [31:0] write_data;
    logic [4:0]  interrupt;
    logic [31:0] data_out, data_out2;
    logic        int_pending, int_pending2;
    logic [8:0]  ip_status;
    logic [6:0]  ip_status2;

    always #5 clk = ~clk;

    cp0_timer_irq #(.NUM_TIMERS(4), .COUNT_WIDTH(32), .HWI_WIDTH(5), .PRESCALE_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .data_out(data_out),
        .interrupt(interrupt), .int_pending(int_pending), .ip_status(ip_status)
    );

    cp0_timer_irq #(.NUM_TIMERS(2), .COUNT_WIDTH(16), .HWI_WIDTH(5), .PRESCALE_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .data_out(data_out2),
        .interrupt(interrupt), .int_pending(int_pending2), .ip_status(ip_status2)
    );

    // kind: 0 data_out, 1 int_pending, 2 ip_status, 3 data_out of 16-bit instance
    typedef struct {
        int          kind;
        logic [31:0] want;
        string       name;
    } chk_t;

    chk_t sb[$];
    logic chk_vld = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    // Monitor: one scoreboard entry per cycle flagged by the stimulus
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] got;
        if (chk_vld) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_underflow: no expected entry queued");
            end else begin
                c = sb.pop_front();
                case (c.kind)
                    0:       got = data_out;
                    1:       got = {31'd0, int_pending};
                    2:       got = 32'(ip_status);
                    default: got = data_out2;
                endcase
                if (got === c.want) n_pass++;
                else $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, got, c.want);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        write_en = 1'b0;
        chk_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic expect_val(input int k, input logic [4:0] a, input logic [31:0] v, input string n);
        read_addr = a;
        sb.push_back('{kind: k, want: v, name: n});
        chk_vld = 1'b1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input string n);
        expect_val(0, a, v, n);
    endtask

    task automatic rd2(input logic [4:0] a, input logic [31:0] v, input string n);
        expect_val(3, a, v, n);
    endtask

    task automatic sig(input int k, input logic [31:0] v, input string n);
        expect_val(k, 5'd0, v, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
        read_addr = '0; interrupt = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        // reset holds outputs low even with all interrupt lines high
        sig(2, 32'h0, "rst_ip_status");          step();
        sig(1, 32'h0, "rst_int_pending");        step();
        rst = 1'b0; interrupt = 5'h00;

        // channel 0 compare = 5, enabled, tick every cycle
        wr(5'd16, 32'd5);                        step();
        wr(5'd24, 32'd1);                        step();
        rd(5'd8, 32'd0, "cnt0_start");           step();
        idle(4);
        sig(2, 32'h000, "no_early_match");       step();
        rd(5'd8, 32'd6, "cnt0_after_match");     step();
        sig(2, 32'h020, "tmr0_pend");  wr(5'd24, 32'd0); step();
        rd(5'd8, 32'd8, "cnt0_disabled");        step();
        rd(5'd8, 32'd8, "cnt0_hold");            step();
        wr(5'd1, 32'h20);                        step();
        sig(2, 32'h000, "w1c_clear");  wr(5'd17, 32'd3); step();

        // channel 1 auto-reload at 3
        wr(5'd25, 32'd3);                        step();
        rd(5'd9, 32'd0, "ar_seq0");              step();
        rd(5'd9, 32'd1, "ar_seq1");              step();
        rd(5'd9, 32'd2, "ar_seq2");              step();
        rd(5'd9, 32'd3, "ar_seq3");              step();
        rd(5'd9, 32'd0, "ar_wrap");              step();
        sig(2, 32'h040, "tmr1_pend");            step();
        rd(5'd9, 32'd2, "ar_seq2b");             step();
        wr(5'd1, 32'h40); rd(5'd9, 32'd3, "ar_seq3b"); step();
        sig(2, 32'h040, "w1c_vs_match"); wr(5'd1, 32'h40); step();
        sig(2, 32'h000, "ar_w1c");     wr(5'd25, 32'd0); step();
        rd(5'd9, 32'd2, "ar_hold");              step();

        // software COUNT write during a tick wins over the increment
        wr(5'd24, 32'd1);                        step();
        wr(5'd8, 32'd100);                       step();
        rd(5'd8, 32'd100, "cnt_wr_tick");        step();
        rd(5'd8, 32'd101, "cnt_inc"); wr(5'd24, 32'd0); step();

        // COMPARE write clears pending; compare of 0 never matches
        wr(5'd8, 32'd4);                         step();
        wr(5'd24, 32'd1);                        step();
        idle(2);
        sig(2, 32'h020, "tmr0_pend2"); wr(5'd24, 32'd0); step();
        wr(5'd16, 32'd0);                        step();
        sig(2, 32'h000, "cmp_wr_clear"); wr(5'd8, 32'd0); step();
        wr(5'd24, 32'd1);                        step();
        step();
        sig(2, 32'h000, "cmp0_nomatch"); wr(5'd24, 32'd0); step();

        // hardware interrupt path and masking
        wr(5'd0, 32'h8000_0001);                 step();
        interrupt = 5'h01; sig(1, 32'h0, "irq_pre"); step();
        sig(1, 32'h1, "irq_on");                 step();
        sig(2, 32'h001, "ip_hwi"); wr(5'd0, 32'h1); step();
        sig(1, 32'h0, "irq_ie_off"); wr(5'd1, 32'h1F); step();
        sig(2, 32'h001, "hwi_not_clr"); interrupt = 5'h00; step();
        sig(2, 32'h000, "hwi_drop");             step();
        rd(5'd0, 32'h1, "mask_rd");              step();
        rd(5'd3, 32'h0, "unmapped3"); wr(5'd3, 32'hFFFF_FFFF); step();
        rd(5'd12, 32'h0, "cnt4_unmapped");       step();

        // prescaler = 3
        rd(5'd17, 32'd3, "cmp1_rd"); wr(5'd2, 32'd3); step();
        wr(5'd8, 32'd0);                         step();
        wr(5'd24, 32'd1);                        step();
        step();
        rd(5'd8, PS ? 32'd0 : 32'd1, "presc_cnt_a"); step();
        rd(5'd8, PS ? 32'd1 : 32'd2, "presc_cnt_b"); step();
        idle(2);
        rd(5'd8, PS ? 32'd1 : 32'd5, "presc_cnt_c"); step();
        rd(5'd8, PS ? 32'd2 : 32'd6, "presc_cnt_d"); wr(5'd24, 32'd0); step();
        rd(5'd2, PS ? 32'd3 : 32'd0, "presc_rd"); wr(5'd2, 32'd0); step();

        // 16-bit wrap and out-of-range channel on the narrow instance
        wr(5'd8, 32'h0000_FFFF);                 step();
        wr(5'd24, 32'd1);                        step();
        rd2(5'd8, 32'h0000_FFFF, "w16_pre");     step();
        rd2(5'd8, 32'h0000_0000, "w16_wrap");    step();
        wr(5'd11, 32'h1234);                     step();
        rd2(5'd11, 32'h0, "nt2_addr11");         step();
        rd(5'd11, 32'h1234, "cnt3_rd");          step();

        // reset one cycle before an imminent match
        wr(5'd16, 32'h0001_0006);                step();
        step();
        rst = 1'b1; rd(5'd8, 32'h0, "rst_dout"); step();
        rst = 1'b0; sig(2, 32'h0, "rst_no_match"); step();
        rd(5'd8, 32'h0, "rst_cnt");              step();
        rd(5'd16, 32'h0, "rst_cmp");             step();

        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
